// File: rtl/square_reconstruct_if.sv
// square_reconstruct_if: operand/result bundle for the square reconstruct unit
interface square_reconstruct_if #(parameter int DATA_WIDTH = 32);
  logic                    data_valid_i;
  logic [DATA_WIDTH/2-1:0] root_i;
  logic [DATA_WIDTH/2:0]   remainder_i;
  logic [DATA_WIDTH-1:0]   radicand_o;
  logic                    data_valid_o;
  logic                    invalid_o;
  logic                    idle_o;
  modport slave (
    input  data_valid_i, root_i, remainder_i,
    output radicand_o, data_valid_o, invalid_o, idle_o
  );
  modport master (
    output data_valid_i, root_i, remainder_i,
    input  radicand_o, data_valid_o, invalid_o, idle_o
  );
endinterface

// File: rtl/square_reconstruct.sv
// square_reconstruct: rebuilds radicand = root*root + remainder, one root bit per cycle
module square_reconstruct #(
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  input logic                 clk_en_i,
  square_reconstruct_if.slave bus
);
  localparam int N  = DATA_WIDTH / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [N-1:0]          r_root;
  logic [N:0]            r_rem;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_radicand;
  logic                  r_valid;
  logic                  r_invalid;
  logic [DATA_WIDTH-1:0] w_addend;
  logic [DATA_WIDTH-1:0] w_sum;
  logic                  w_invalid;
  // MSB-first shift-add: each step doubles the partial product and adds root if the current root bit is set
  assign w_addend  = r_root[r_cnt] ? {{N{1'b0}}, r_root} : '0;
  // carry out of the final add is dropped; it can only occur for an invalid pair
  assign w_sum     = r_acc + {{(DATA_WIDTH-N-1){1'b0}}, r_rem};
  assign w_invalid = r_rem > {r_root, 1'b0};
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_root     <= '0;
      r_rem      <= '0;
      r_acc      <= '0;
      r_radicand <= '0;
      r_valid    <= 1'b0;
      r_invalid  <= 1'b0;
    end else if (clk_en_i) begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: if (bus.data_valid_i) begin
          r_root  <= bus.root_i;
          r_rem   <= bus.remainder_i;
          r_acc   <= '0;
          r_cnt   <= CNT_INIT;
          r_state <= MULT;
        end
        MULT: begin
          r_acc   <= {r_acc[DATA_WIDTH-2:0], 1'b0} + w_addend;
          r_cnt   <= r_cnt - 1'b1;
          r_state <= (r_cnt == '0) ? DONE : MULT;
        end
        DONE: begin
          r_radicand <= w_sum;
          r_invalid  <= w_invalid;
          r_valid    <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.radicand_o   = r_radicand;
  assign bus.data_valid_o = r_valid;
  assign bus.invalid_o    = r_invalid;
  assign bus.idle_o       = (r_state == IDLE);
endmodule
